// File: rtl/ins_fetch_queue.sv
// Instruction staging queue in front of the dispatcher: FIFO, held output register, program tracking.
// Optional per-opcode statistics are compiled in when INS_FETCH_STAT_EN is defined.
module ins_fetch_queue #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned INST_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic [INST_W-1:0] host_data,
    input  logic              host_last,
    output logic              ins_valid,
    input  logic              ins_ready,
    output logic [INST_W-1:0] ins,
    input  logic              working,
    output logic              busy,
    output logic              prog_done,
    output logic [15:0]       ins_count,
    output logic [15:0]       cnt_load,
    output logic [15:0]       cnt_calc,
    output logic [15:0]       cnt_save,
    output logic [15:0]       cnt_conf
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    logic [INST_W:0]   mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     fifo_cnt_q, fifo_cnt_d, occ;
    logic              out_valid_q, out_last_q;
    logic [INST_W-1:0] out_data_q;
    state_t            state_q, state_d;
    logic              seen_zero_q, seen_zero_d;
    logic              prog_done_q, prog_done_d;
    logic [15:0]       ins_count_q, ins_count_d;
    logic              push, hs, issue_en, load;

    // Occupancy includes the presented entry, so DEPTH bounds the whole queue.
    assign occ        = fifo_cnt_q + CW'(out_valid_q);
    assign host_ready = (occ < CW'(DEPTH));
    assign push       = host_valid && host_ready;
    assign hs         = out_valid_q && ins_ready;
    // The last handshake of a program must not pull in the next program's head.
    assign issue_en   = ((state_q == IDLE) || (state_q == RUN)) && !(hs && out_last_q);
    assign load       = issue_en && (fifo_cnt_q != '0) && (!out_valid_q || hs);
    assign fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(load);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {host_last, host_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            fifo_cnt_q <= fifo_cnt_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (load) begin
                rd_ptr_q                  <= rd_ptr_q + AW'(1);
                out_valid_q               <= 1'b1;
                {out_last_q, out_data_q}  <= mem_q[rd_ptr_q];
            end else if (hs) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            seen_zero_q <= 1'b0;
            prog_done_q <= 1'b0;
            ins_count_q <= '0;
        end else begin
            state_q     <= state_d;
            seen_zero_q <= seen_zero_d;
            prog_done_q <= prog_done_d;
            ins_count_q <= ins_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        seen_zero_d = 1'b0;
        prog_done_d = 1'b0;
        ins_count_d = ins_count_q;
        unique case (state_q)
            IDLE: begin
                if (hs) begin
                    ins_count_d = 16'd1;
                    state_d     = out_last_q ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (hs) begin
                    ins_count_d = ins_count_q + 16'd1;
                    if (out_last_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Two idle samples in a row absorb the dispatcher's registered lag.
                if (!working) begin
                    if (seen_zero_q) begin
                        state_d = DONE;
                    end else begin
                        seen_zero_d = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d     = IDLE;
                prog_done_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ins_valid = out_valid_q;
    assign ins       = out_data_q;
    assign prog_done = prog_done_q;
    assign ins_count = ins_count_q;
    assign busy      = (state_q != IDLE) || (fifo_cnt_q != '0) || out_valid_q;

`ifdef INS_FETCH_STAT_EN
    logic [15:0] stat_q [4];
    logic [1:0]  op;

    assign op = out_data_q[INST_W-1 -: 2];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 4; i++) begin
                stat_q[i] <= '0;
            end
        end else if (hs) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (2'(i) == op) begin
                    if (state_q == IDLE) begin
                        stat_q[i] <= 16'd1;
                    end else if (stat_q[i] != '1) begin
                        stat_q[i] <= stat_q[i] + 16'd1;
                    end
                end else if (state_q == IDLE) begin
                    stat_q[i] <= '0;
                end
            end
        end
    end

    assign cnt_load = stat_q[0];
    assign cnt_calc = stat_q[1];
    assign cnt_save = stat_q[2];
    assign cnt_conf = stat_q[3];
`else
    assign cnt_load = '0;
    assign cnt_calc = '0;
    assign cnt_save = '0;
    assign cnt_conf = '0;
`endif

endmodule

// File: tb/tb_ins_fetch_queue.sv
// Directed self-checking bench for ins_fetch_queue (DEPTH=16, INST_W=64).
module tb_ins_fetch_queue;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned INST_W = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              host_valid = 1'b0;
    logic              host_ready;
    logic [INST_W-1:0] host_data = '0;
    logic              host_last = 1'b0;
    logic              ins_valid;
    logic              ins_ready = 1'b0;
    logic [INST_W-1:0] ins;
    logic              working = 1'b1;
    logic              busy;
    logic              prog_done;
    logic [15:0]       ins_count;
    logic [15:0]       cnt_load, cnt_calc, cnt_save, cnt_conf;

    int checks = 0;
    int errors = 0;

    ins_fetch_queue #(.DEPTH(DEPTH), .INST_W(INST_W)) dut (
        .clk(clk), .rst(rst),
        .host_valid(host_valid), .host_ready(host_ready),
        .host_data(host_data), .host_last(host_last),
        .ins_valid(ins_valid), .ins_ready(ins_ready), .ins(ins),
        .working(working), .busy(busy), .prog_done(prog_done),
        .ins_count(ins_count),
        .cnt_load(cnt_load), .cnt_calc(cnt_calc),
        .cnt_save(cnt_save), .cnt_conf(cnt_conf)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] mk(input logic [1:0] op, input int id);
        return {op, 46'd0, id[15:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; host_valid = 1'b0; ins_ready = 1'b0; working = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic push_one(input logic [63:0] d, input logic last);
        bit ok = 0;
        host_valid = 1'b1; host_data = d; host_last = last;
        for (int i = 0; i < 40; i++) begin
            if (host_ready) begin
                tick();
                ok = 1;
                break;
            end
            tick();
        end
        host_valid = 1'b0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL push_timeout: host_ready=0 for 40 cycles, required 1");
        end
    endtask

    task automatic wait_valid();
        bit ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (ins_valid) begin
                ok = 1;
                break;
            end
            tick();
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL valid_timeout: ins_valid=0 for 40 cycles, required 1");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; host_valid = 1'b0; ins_ready = 1'b0; working = 1'b1;
        tick(); tick();
        checks++;
        if ({ins_valid, prog_done, busy} !== 3'b000 || ins !== '0 || ins_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%0b done=%0b busy=%0b ins=%h cnt=%0d, required all 0",
                     ins_valid, prog_done, busy, ins, ins_count);
        end
        checks++;
        if ({cnt_load, cnt_calc, cnt_save, cnt_conf} !== '0) begin
            errors++;
            $display("FAIL reset_stats: %h %h %h %h, required 0", cnt_load, cnt_calc, cnt_save, cnt_conf);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (host_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_host_ready: got %0b, required 1", host_ready);
        end
    endtask

    task automatic test_in_order();
        logic [63:0] exp [3];
        exp[0] = mk(2'b11, 1); exp[1] = mk(2'b00, 2); exp[2] = mk(2'b01, 3);
        for (int k = 0; k < 3; k++) push_one(exp[k], k == 2);
        for (int k = 0; k < 3; k++) begin
            wait_valid();
            checks++;
            if (ins !== exp[k]) begin
                errors++;
                $display("FAIL order_ins%0d: got %h, required %h", k, ins, exp[k]);
            end
            for (int w = 0; w < 2; w++) begin
                tick();
                checks++;
                if (ins_valid !== 1'b1 || ins !== exp[k]) begin
                    errors++;
                    $display("FAIL stable_ins%0d: valid=%0b ins=%h, required 1 %h", k, ins_valid, ins, exp[k]);
                end
            end
            ins_ready = 1'b1;
            tick();
            ins_ready = 1'b0;
            checks++;
            if (ins_count !== 16'(k + 1)) begin
                errors++;
                $display("FAIL order_count%0d: got %0d, required %0d", k, ins_count, k + 1);
            end
        end
        checks++;
        if (ins_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL drain_entry: valid=%0b busy=%0b, required 0 1", ins_valid, busy);
        end
    endtask

    task automatic test_drain_done();
        int pulses = 0;
        push_one(mk(2'b10, 10), 1'b0);
        push_one(mk(2'b10, 11), 1'b1);
        working = 1'b1;
        tick(); tick();
        checks++;
        if (ins_valid !== 1'b0 || prog_done !== 1'b0) begin
            errors++;
            $display("FAIL drain_stall: valid=%0b done=%0b, required 0 0", ins_valid, prog_done);
        end
        working = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (prog_done) pulses++;
            checks++;
            if (prog_done !== (i == 3)) begin
                errors++;
                $display("FAIL done_timing_c%0d: prog_done=%0b, required %0b", i, prog_done, i == 3);
            end
            if (i <= 3) begin
                checks++;
                if (ins_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL drain_valid_c%0d: got %0b, required 0", i, ins_valid);
                end
            end else if (i == 4) begin
                checks++;
                if (ins_valid !== 1'b1 || ins !== mk(2'b10, 10)) begin
                    errors++;
                    $display("FAIL reissue: valid=%0b ins=%h, required 1 %h", ins_valid, ins, mk(2'b10, 10));
                end
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL done_pulses: got %0d, required 1", pulses);
        end
        working = 1'b1;
    endtask

    task automatic test_full();
        do_reset();
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (host_ready !== 1'b1) begin
                errors++;
                $display("FAIL fill_ready%0d: got 0, required 1", k);
            end
            push_one(mk(2'(k), 100 + k), 1'b0);
        end
        checks++;
        if (host_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ready: got %0b, required 0", host_ready);
        end
        host_valid = 1'b1; host_data = mk(2'b11, 116); host_last = 1'b1;
        tick(); tick();
        checks++;
        if (host_ready !== 1'b0 || ins_valid !== 1'b1 || ins !== mk(2'b00, 100)) begin
            errors++;
            $display("FAIL full_hold: ready=%0b valid=%0b ins=%h, required 0 1 %h",
                     host_ready, ins_valid, ins, mk(2'b00, 100));
        end
        ins_ready = 1'b1;
        checks++;
        if (host_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_pop_ready: got %0b, required 0", host_ready);
        end
        tick();
        ins_ready = 1'b0;
        checks++;
        if (host_ready !== 1'b1) begin
            errors++;
            $display("FAIL after_pop_ready: got %0b, required 1", host_ready);
        end
        tick();
        host_valid = 1'b0;
        checks++;
        if (host_ready !== 1'b0) begin
            errors++;
            $display("FAIL refull_ready: got %0b, required 0", host_ready);
        end
        ins_ready = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            logic [63:0] e;
            e = (k == 16) ? mk(2'b11, 116) : mk(2'(k), 100 + k);
            checks++;
            if (ins_valid !== 1'b1 || ins !== e) begin
                errors++;
                $display("FAIL full_drain%0d: valid=%0b ins=%h, required 1 %h", k, ins_valid, ins, e);
            end
            tick();
        end
        ins_ready = 1'b0;
        checks++;
        if (ins_valid !== 1'b0 || ins_count !== 16'd17) begin
            errors++;
            $display("FAIL full_end: valid=%0b count=%0d, required 0 17", ins_valid, ins_count);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < 4; k++) push_one(mk(2'(k), 200 + k), k == 3);
        wait_valid();
        ins_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (ins_valid !== 1'b1 || ins !== mk(2'(k), 200 + k)) begin
                errors++;
                $display("FAIL b2b%0d: valid=%0b ins=%h, required 1 %h", k, ins_valid, ins, mk(2'(k), 200 + k));
            end
            tick();
        end
        checks++;
        if (ins_valid !== 1'b0 || ins_count !== 16'd4) begin
            errors++;
            $display("FAIL b2b_end: valid=%0b count=%0d, required 0 4", ins_valid, ins_count);
        end
        tick();
        ins_ready = 1'b0;
        checks++;
        if (ins_count !== 16'd4) begin
            errors++;
            $display("FAIL ready_no_valid: count=%0d, required 4", ins_count);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int k = 0; k < 5; k++) push_one(mk(2'b01, 300 + k), k == 4);
        wait_valid();
        ins_ready = 1'b1;
        tick();
        ins_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({ins_valid, busy, prog_done} !== 3'b000 || ins_count !== 16'd0 || ins !== '0) begin
                errors++;
                $display("FAIL mid_reset_c%0d: valid=%0b busy=%0b done=%0b cnt=%0d ins=%h, required 0",
                         i, ins_valid, busy, prog_done, ins_count, ins);
            end
            tick();
        end
        push_one(mk(2'b10, 400), 1'b0);
        push_one(mk(2'b11, 401), 1'b1);
        for (int k = 0; k < 2; k++) begin
            wait_valid();
            checks++;
            if (ins !== mk(2'(k + 2), 400 + k)) begin
                errors++;
                $display("FAIL post_reset%0d: got %h, required %h", k, ins, mk(2'(k + 2), 400 + k));
            end
            ins_ready = 1'b1;
            tick();
            ins_ready = 1'b0;
        end
        checks++;
        if (ins_count !== 16'd2) begin
            errors++;
            $display("FAIL post_reset_count: got %0d, required 2", ins_count);
        end
    endtask

    task automatic test_stats();
        logic [1:0] ops [7];
        bit seen = 0;
        ops[0] = 2'b00; ops[1] = 2'b01; ops[2] = 2'b00; ops[3] = 2'b01;
        ops[4] = 2'b10; ops[5] = 2'b01; ops[6] = 2'b11;
        do_reset();
        for (int k = 0; k < 7; k++) push_one(mk(ops[k], 500 + k), k == 6);
        wait_valid();
        ins_ready = 1'b1;
        for (int k = 0; k < 7; k++) tick();
        ins_ready = 1'b0;
        checks++;
`ifdef INS_FETCH_STAT_EN
        if ({cnt_load, cnt_calc, cnt_save, cnt_conf} !== {16'd2, 16'd3, 16'd1, 16'd1}) begin
            errors++;
            $display("FAIL stats_prog: %0d %0d %0d %0d, required 2 3 1 1", cnt_load, cnt_calc, cnt_save, cnt_conf);
        end
`else
        if ({cnt_load, cnt_calc, cnt_save, cnt_conf} !== '0) begin
            errors++;
            $display("FAIL stats_off: %0d %0d %0d %0d, required 0 0 0 0", cnt_load, cnt_calc, cnt_save, cnt_conf);
        end
`endif
        working = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (prog_done) begin
                seen = 1;
                break;
            end
        end
        working = 1'b1;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL stats_done: prog_done not seen in 10 cycles, required pulse");
        end
        push_one(mk(2'b01, 600), 1'b1);
        wait_valid();
        ins_ready = 1'b1;
        tick();
        ins_ready = 1'b0;
        checks++;
`ifdef INS_FETCH_STAT_EN
        if ({cnt_load, cnt_calc, cnt_save, cnt_conf} !== {16'd0, 16'd1, 16'd0, 16'd0} || ins_count !== 16'd1) begin
            errors++;
            $display("FAIL stats_clear: %0d %0d %0d %0d cnt=%0d, required 0 1 0 0 cnt=1",
                     cnt_load, cnt_calc, cnt_save, cnt_conf, ins_count);
        end
`else
        if ({cnt_load, cnt_calc, cnt_save, cnt_conf} !== '0 || ins_count !== 16'd1) begin
            errors++;
            $display("FAIL stats_clear: %0d %0d %0d %0d cnt=%0d, required 0 0 0 0 cnt=1",
                     cnt_load, cnt_calc, cnt_save, cnt_conf, ins_count);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_drain_done();
        test_full();
        test_back_to_back();
        test_mid_reset();
        test_stats();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end

endmodule
